// File: rtl/hazard_ctrl_n.sv
// Pipeline hazard controller: per-latch enables/flushes and PC enable by fixed priority,
// with registered tracking of data-memory waits, multi-cycle load-use stalls and halt.
module hazard_ctrl_n #(
    parameter int NLATCH      = 4,
    parameter int REGW        = 5,
    parameter int LU_STALL    = 1,
    parameter int BR_FLUSH    = 2,
    parameter bit SHARED_PORT = 1'b1,
    parameter int CNTW        = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_req,
    input  logic              halt,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic              ex_memread,
    input  logic [REGW-1:0]   ex_rd,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    output logic              pc_en,
    output logic [NLATCH-1:0] en,
    output logic [NLATCH-1:0] flush,
    output logic              halted,
    output logic [CNTW-1:0]   stall_cnt,
    output logic [1:0]        dbg_state
);

    localparam int LUW = $clog2(LU_STALL + 1);

    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, LUSTALL = 2'd2, HALTED = 2'd3} state_t;

    state_t           state, state_n;
    logic [LUW-1:0]   lu_cnt, lu_cnt_n;
    logic             lu_hit;

    // Priorities 2..7, shared by RUN/LUSTALL and by DWAIT on its completing cycle.
    logic              ev_pc_en;
    logic [NLATCH-1:0] ev_en, ev_flush;
    state_t            ev_state;
    logic [LUW-1:0]    ev_lu;
    logic              ev_higher;

    assign lu_hit    = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign dbg_state = state;

    always_comb begin
        ev_pc_en  = 1'b1;
        ev_en     = '1;
        ev_flush  = '0;
        ev_state  = RUN;
        ev_lu     = lu_cnt;
        ev_higher = 1'b0;
        if (halt) begin
            ev_pc_en          = 1'b0;
            ev_en             = '0;
            ev_en[NLATCH-1]   = 1'b1;
            ev_state          = HALTED;
            ev_higher         = 1'b1;
        end else if (branch_taken) begin
            for (int i = 0; i < NLATCH; i++) begin
                if (i < BR_FLUSH) ev_flush[i] = 1'b1;
            end
            ev_lu     = '0;
            ev_higher = 1'b1;
        end else if (jump) begin
            ev_flush[0] = 1'b1;
            ev_lu       = '0;
            ev_higher   = 1'b1;
        end else if (state == LUSTALL || lu_hit) begin
            ev_pc_en    = 1'b0;
            ev_en[0]    = 1'b0;
            ev_flush[1] = 1'b1;
            if (state == LUSTALL) begin
                if (lu_cnt <= LUW'(1)) begin
                    ev_lu = '0;
                end else begin
                    ev_lu    = lu_cnt - LUW'(1);
                    ev_state = LUSTALL;
                end
            end else if (LU_STALL > 1) begin
                ev_lu    = LUW'(LU_STALL - 1);
                ev_state = LUSTALL;
            end
        end else if (!ihit) begin
            ev_pc_en    = 1'b0;
            ev_flush[0] = 1'b1;
        end
    end

    always_comb begin
        pc_en    = 1'b1;
        en       = '1;
        flush    = '0;
        state_n  = state;
        lu_cnt_n = lu_cnt;
        case (state)
            HALTED: begin
                pc_en = 1'b0;
                en    = '0;
            end
            DWAIT: begin
                if (!dhit) begin
                    pc_en = 1'b0;
                    en    = '0;
                end else begin
                    pc_en    = ev_pc_en;
                    en       = ev_en;
                    flush    = ev_flush;
                    flush[0] = ev_flush[0] | SHARED_PORT;
                    state_n  = ev_state;
                    lu_cnt_n = ev_lu;
                    // A load-use stall interrupted by the wait resumes where it left off.
                    if (lu_cnt != '0 && !ev_higher) begin
                        state_n  = LUSTALL;
                        lu_cnt_n = lu_cnt;
                    end
                end
            end
            default: begin
                if (mem_req && !dhit) begin
                    pc_en   = 1'b0;
                    en      = '0;
                    state_n = DWAIT;
                end else begin
                    pc_en    = ev_pc_en;
                    en       = ev_en;
                    flush    = ev_flush;
                    state_n  = ev_state;
                    lu_cnt_n = ev_lu;
                end
            end
        endcase
        if (!nRST) begin
            pc_en = 1'b0;
            en    = '0;
            flush = '1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            lu_cnt    <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= state_n;
            lu_cnt <= lu_cnt_n;
            if (state_n == HALTED) halted <= 1'b1;
            if (!pc_en && state != HALTED && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// Directed bench for hazard_ctrl_n with LU_STALL=2, BR_FLUSH=2, SHARED_PORT=1, CNTW=4.
module tb_hazard_ctrl_n;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, mem_req, halt, jump, branch_taken, ex_memread;
    logic [4:0] ex_rd, id_rs, id_rt;
    logic       pc_en, halted;
    logic [3:0] en, flush, stall_cnt;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_n #(
        .NLATCH(4), .REGW(5), .LU_STALL(2), .BR_FLUSH(2), .SHARED_PORT(1'b1), .CNTW(4)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req), .halt(halt),
        .jump(jump), .branch_taken(branch_taken), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_rs(id_rs), .id_rt(id_rt), .pc_en(pc_en), .en(en), .flush(flush),
        .halted(halted), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; halt = 1'b0; jump = 1'b0;
        branch_taken = 1'b0; ex_memread = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
    endtask

    task automatic do_reset();
        #1 nRST = 1'b0;
        #1 nRST = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic p, input logic [3:0] e,
                              input logic [3:0] f);
        check({tag, "_pc_en"}, 32'(p), 32'(pc_en));
        check({tag, "_en"}, 32'(en), 32'(e));
        check({tag, "_flush"}, 32'(flush), 32'(f));
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b0;
        #2;
        check_outs("reset", 1'b0, 4'b0000, 4'b1111);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        tick();
        nRST = 1'b1;

        // Load-use: ex_rd=8 matches id_rt -> exactly two stall cycles.
        ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_rs = 5'd3;
        #2 check_outs("lu_c1", 1'b0, 4'b1110, 4'b0010);
        tick();
        check("lu_state", 32'(dbg_state), 32'd2);
        ex_memread = 1'b0;
        #2 check_outs("lu_c2", 1'b0, 4'b1110, 4'b0010);
        tick();
        check_outs("lu_done", 1'b1, 4'b1111, 4'b0000);
        check("lu_cnt", 32'(stall_cnt), 32'd2);
        ex_memread = 1'b1; ex_rd = 5'd0; id_rt = 5'd0;
        #2 check_outs("lu_r0", 1'b1, 4'b1111, 4'b0000);
        tick();
        check("lu_r0_cnt", 32'(stall_cnt), 32'd2);

        // Data wait: 3 cycles of dhit low, then completion flushes IF/ID.
        clear_inputs();
        do_reset();
        mem_req = 1'b1; dhit = 1'b0;
        #2 check_outs("dw_c1", 1'b0, 4'b0000, 4'b0000);
        tick();
        check("dw_state", 32'(dbg_state), 32'd1);
        check_outs("dw_c2", 1'b0, 4'b0000, 4'b0000);
        tick();
        check_outs("dw_c3", 1'b0, 4'b0000, 4'b0000);
        tick();
        dhit = 1'b1;
        #2 check_outs("dw_hit", 1'b1, 4'b1111, 4'b0001);
        tick();
        check("dw_cnt", 32'(stall_cnt), 32'd3);
        check("dw_back", 32'(dbg_state), 32'd0);

        // Asynchronous reset in the middle of a data wait.
        dhit = 1'b0;
        tick();
        check("rst_pre", 32'(dbg_state), 32'd1);
        #1 nRST = 1'b0;
        #1 check_outs("rst_mid", 1'b0, 4'b0000, 4'b1111);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        nRST = 1'b1;
        clear_inputs();
        #1 check_outs("rst_rel", 1'b1, 4'b1111, 4'b0000);
        tick();
        check("rst_cnt_after", 32'(stall_cnt), 32'd0);

        // Branch + jump + load-use together: branch wins.
        branch_taken = 1'b1; jump = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        #2 check_outs("bj", 1'b1, 4'b1111, 4'b0011);
        tick();
        check("bj_state", 32'(dbg_state), 32'd0);
        check("bj_cnt", 32'(stall_cnt), 32'd0);
        clear_inputs();
        #2 check_outs("bj_next", 1'b1, 4'b1111, 4'b0000);
        tick();

        // Halt beats branch, then everything is frozen.
        halt = 1'b1; branch_taken = 1'b1;
        #2 check_outs("halt", 1'b0, 4'b1000, 4'b0000);
        check("halt_pre", 32'(halted), 32'd0);
        tick();
        clear_inputs();
        check("halted", 32'(halted), 32'd1);
        check("halt_state", 32'(dbg_state), 32'd3);
        for (int i = 0; i < 4; i++) begin
            ihit = i[0]; dhit = ~i[0]; mem_req = i[1];
            #2 check_outs("halt_hold", 1'b0, 4'b0000, 4'b0000);
            tick();
            check("halt_sticky", 32'(halted), 32'd1);
        end
        check("halt_cnt", 32'(stall_cnt), 32'd1);

        // Fetch miss for 20 cycles: counter saturates at 15.
        clear_inputs();
        do_reset();
        check("sat_unhalt", 32'(halted), 32'd0);
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2 check_outs("imiss", 1'b0, 4'b1111, 4'b0001);
            tick();
        end
        check("sat_cnt", 32'(stall_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
